reg_file_sb: RTL and testbench

Parametrised register file with integrated scoreboard for the ARM pipeline decode stage. It provides RD_PORTS combinational read ports and one synchronous write-back port. It also keeps a per-register count of in-flight writes, so decode can raise `hazard` without comparing addresses against every downstream stage. The block sits inside the ID stage, between the instruction decoder and the ID/EXE pipeline register. It replaces the fixed 2-read, negedge-write register file.

---
 rtl/reg_file_sb.sv | 149 ++++++++++++++
 tb/tb_reg_file_sb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Register file with an integrated write-back scoreboard for the decode
// stage. Provides RD_PORTS combinational read ports and one synchronous
// write-back port. A per-register in-flight counter lets decode raise
// `hazard` without comparing against every downstream stage.
//
// Optional feature: define WB_BYPASS_EN to forward the write-back value to
// matching read ports in the same cycle. Forwarding also treats the
// retiring write as already gone for busy/full evaluation.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rd_addr/rd_used read addresses and "is a real source" flags, per port
//   rd_data         combinational read data, per port
//   issue_valid     instruction presented at decode
//   issue_wb_en     that instruction will write back to issue_dest
//   flush           instruction at issue is squashed
//   hazard          issue must stall
//   issue_ok        instruction accepted this cycle
//   wb_en/wb_dest/wb_value  write-back port
//   sb_err          sticky flag: write-back to a register with no writes
//                   in flight
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 15,
    parameter int RD_PORTS = 3,
    parameter int CNT_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    input  logic [RD_PORTS-1:0]          rd_used,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    input  logic                         issue_valid,
    input  logic                         issue_wb_en,
    input  logic [ADDR_W-1:0]            issue_dest,
    input  logic                         flush,
    output logic                         hazard,
    output logic                         issue_ok,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_dest,
    input  logic [DATA_W-1:0]            wb_value,
    output logic                         sb_err
);

    localparam logic [CNT_W-1:0] MAXC = '1;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [CNT_W-1:0]    cnt  [NUM_REGS];

    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] full;
    logic                src_hz;
    logic                full_hz;
    logic                wb_zero;

    // Per-register write-back match, decrement, and busy/full status.
    // Unimplemented addresses never match any register, so they are never
    // busy and writes to them fall away naturally.
    always_comb begin
        wb_hit = '0;
        dec    = '0;
        busy   = '0;
        full   = '0;
        for (int a = 0; a < NUM_REGS; a++) begin
            wb_hit[a] = wb_en && (wb_dest == ADDR_W'(a));
            dec[a]    = wb_hit[a] && (cnt[a] != '0);
`ifdef WB_BYPASS_EN
            // The retiring write no longer counts as in flight.
            busy[a]   = (cnt[a] - CNT_W'(dec[a])) != '0;
            full[a]   = (cnt[a] - CNT_W'(dec[a])) == MAXC;
`else
            busy[a]   = cnt[a] != '0;
            full[a]   = cnt[a] == MAXC;
`endif
        end
        // Write-back hitting a register whose count is already zero.
        wb_zero = |(wb_hit & ~dec);
    end

    // Read ports and source hazard detection.
    always_comb begin
        rd_data = '0;
        src_hz  = 1'b0;
        for (int i = 0; i < RD_PORTS; i++) begin
            for (int a = 0; a < NUM_REGS; a++) begin
                if (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(a)) begin
                    rd_data[i*DATA_W +: DATA_W] = regs[a];
`ifdef WB_BYPASS_EN
                    if (wb_hit[a]) begin
                        rd_data[i*DATA_W +: DATA_W] = wb_value;
                    end
`endif
                    if (rd_used[i] && busy[a]) begin
                        src_hz = 1'b1;
                    end
                end
            end
        end
    end

    // Issue decision and counter increments.
    always_comb begin
        full_hz = 1'b0;
        for (int a = 0; a < NUM_REGS; a++) begin
            if (issue_wb_en && (issue_dest == ADDR_W'(a)) && full[a]) begin
                full_hz = 1'b1;
            end
        end
        hazard   = issue_valid && !flush && (src_hz || full_hz);
        issue_ok = issue_valid && !flush && !hazard;
        inc      = '0;
        for (int a = 0; a < NUM_REGS; a++) begin
            inc[a] = issue_ok && issue_wb_en && (issue_dest == ADDR_W'(a));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_REGS; a++) begin
                regs[a] <= '0;
                cnt[a]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int a = 0; a < NUM_REGS; a++) begin
                if (wb_hit[a]) begin
                    regs[a] <= wb_value;
                end
                // Simultaneous issue and retire leave the count unchanged.
                if (inc[a] && !dec[a]) begin
                    cnt[a] <= cnt[a] + CNT_W'(1);
                end else if (dec[a] && !inc[a]) begin
                    cnt[a] <= cnt[a] - CNT_W'(1);
                end
            end
            if (wb_zero) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NR   = 15;
    localparam int RP   = 3;
    localparam int MAXC = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [RP*AW-1:0]  rd_addr;
    logic [RP-1:0]     rd_used;
    logic [RP*DW-1:0]  rd_data;
    logic              issue_valid;
    logic              issue_wb_en;
    logic [AW-1:0]     issue_dest;
    logic              flush;
    logic              hazard;
    logic              issue_ok;
    logic              wb_en;
    logic [AW-1:0]     wb_dest;
    logic [DW-1:0]     wb_value;
    logic              sb_err;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: plain arrays of values and in-flight counts.
    logic [DW-1:0] mreg [16];
    int            mcnt [16];
    bit            msb;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
        .issue_dest(issue_dest), .flush(flush),
        .hazard(hazard), .issue_ok(issue_ok),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .sb_err(sb_err)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Outstanding writes to a, as seen by an instruction at issue now.
    function automatic int eff(int a);
        int c;
        if (a >= NR) return 0;
        c = mcnt[a];
`ifdef WB_BYPASS_EN
        if (wb_en && int'(wb_dest) == a && c > 0) c = c - 1;
`endif
        return c;
    endfunction

    function automatic logic [DW-1:0] m_rd(int i);
        int a;
        a = int'(rd_addr[i*AW +: AW]);
        if (a >= NR) return '0;
`ifdef WB_BYPASS_EN
        if (wb_en && int'(wb_dest) == a) return wb_value;
`endif
        return mreg[a];
    endfunction

    function automatic bit m_hazard();
        bit hz;
        hz = 1'b0;
        for (int i = 0; i < RP; i++)
            if (rd_used[i] && eff(int'(rd_addr[i*AW +: AW])) > 0) hz = 1'b1;
        if (issue_wb_en && int'(issue_dest) < NR && eff(int'(issue_dest)) == MAXC) hz = 1'b1;
        return issue_valid && !flush && hz;
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 16; a++) begin
            mreg[a] = '0;
            mcnt[a] = 0;
        end
        msb = 1'b0;
    endtask

    // Compare all outputs against the model, advance the model, clock once.
    task automatic cycle(string tag, bit chk = 1'b1);
        bit hz;
        bit ok;
        int wd;
        int id;
        @(negedge clk);
        hz = m_hazard();
        ok = issue_valid && !flush && !hz;
        if (chk) begin
            for (int i = 0; i < RP; i++)
                check($sformatf("%s/rd%0d", tag, i), 64'(rd_data[i*DW +: DW]), 64'(m_rd(i)));
            check({tag, "/hazard"}, 64'(hazard), 64'(hz));
            check({tag, "/issue_ok"}, 64'(issue_ok), 64'(ok));
            check({tag, "/sb_err"}, 64'(sb_err), 64'(msb));
        end
        if (rst) begin
            model_clear();
        end else begin
            wd = int'(wb_dest);
            id = int'(issue_dest);
            if (wb_en && wd < NR) begin
                mreg[wd] = wb_value;
                if (mcnt[wd] == 0) msb = 1'b1;
                else mcnt[wd] = mcnt[wd] - 1;
            end
            if (ok && issue_wb_en && id < NR) mcnt[id] = mcnt[id] + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = '0; flush = 1'b0;
        rd_addr = '0; rd_used = '0;
        wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    endtask

    function automatic logic [AW-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 4'd0;
            1: return 4'd1;
            2: return 4'd2;
            3: return 4'd3;
            4: return 4'd14;
            5: return 4'd15;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        model_clear();
        cycle("init", 1'b0);
        cycle("init", 1'b0);
        rst = 1'b0;

        // Reset after random writes
        for (int k = 0; k < 6; k++) begin
            idle();
            wb_en = 1'b1; wb_dest = 4'($urandom_range(0, 14)); wb_value = $urandom;
            cycle("prewr");
        end
        idle();
        rst = 1'b1;
        cycle("rst0");
        cycle("rst1");
        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            idle();
            issue_valid = 1'b1;
            rd_addr = {RP{4'(a)}};
            rd_used = '1;
            #1;
            check($sformatf("rst_rd%0d", a), 64'(rd_data), 64'(0));
            check($sformatf("rst_hz%0d", a), 64'(hazard), 64'(0));
            cycle("rst_scan");
        end

        // Basic RAW hazard on R2
        idle();
        issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd2;
        cycle("raw_t");
        idle();
        issue_valid = 1'b1; rd_addr = {4'd0, 4'd0, 4'd2}; rd_used = 3'b001;
        #1;
        check("raw_t1_hazard", 64'(hazard), 64'(1));
        check("raw_t1_ok", 64'(issue_ok), 64'(0));
        cycle("raw_t1");
        cycle("raw_t2");
        wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'd5;
        #1;
`ifdef WB_BYPASS_EN
        check("raw_t3_rd", 64'(rd_data[DW-1:0]), 64'(5));
        check("raw_t3_ok", 64'(issue_ok), 64'(1));
`else
        check("raw_t3_hazard", 64'(hazard), 64'(1));
`endif
        cycle("raw_t3");
`ifndef WB_BYPASS_EN
        wb_en = 1'b0;
        #1;
        check("raw_t4_rd", 64'(rd_data[DW-1:0]), 64'(5));
        check("raw_t4_ok", 64'(issue_ok), 64'(1));
        cycle("raw_t4");
`endif

        // Counter saturation on R1
        idle();
        issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd1;
        repeat (3) cycle("sat_inc");
        #1;
        check("sat4_hazard", 64'(hazard), 64'(1));
        cycle("sat4");
        wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'd7;
        #1;
`ifdef WB_BYPASS_EN
        check("sat_wb_ok", 64'(issue_ok), 64'(1));
`else
        check("sat_wb_ok", 64'(issue_ok), 64'(0));
`endif
        cycle("sat_wb");
        idle();
        issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd1;
        #1;
`ifdef WB_BYPASS_EN
        check("sat_still_full", 64'(hazard), 64'(1));
`else
        check("sat_room_again", 64'(hazard), 64'(0));
`endif
        idle();
        wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'd9;
        repeat (3) cycle("sat_drain");

        // Flush and unused ports
        idle();
        issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd2;
        cycle("fl_prod");
        idle();
        issue_valid = 1'b1; flush = 1'b1; rd_addr = {4'd0, 4'd0, 4'd2}; rd_used = 3'b001;
        issue_wb_en = 1'b1; issue_dest = 4'd5;
        #1;
        check("flush_hazard", 64'(hazard), 64'(0));
        check("flush_ok", 64'(issue_ok), 64'(0));
        cycle("flush");
        idle();
        issue_valid = 1'b1; rd_addr = {4'd2, 4'd2, 4'd2}; rd_used = 3'b000;
        #1;
        check("unused_hazard", 64'(hazard), 64'(0));
        check("unused_ok", 64'(issue_ok), 64'(1));
        cycle("unused");
        idle();
        issue_valid = 1'b1; rd_addr = {4'd5, 4'd0, 4'd0}; rd_used = 3'b100;
        #1;
        check("flush_no_inc", 64'(hazard), 64'(0));
        cycle("flush_no_inc");
        idle();
        wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'hA5;
        cycle("fl_drain");

        // Underflow and unimplemented address
        idle();
        rst = 1'b1;
        cycle("uf_rst");
        rst = 1'b0;
        wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h1234;
        cycle("uf_wb");
        idle();
        rd_addr = {4'd0, 4'd0, 4'd3};
        #1;
        check("uf_rd", 64'(rd_data[DW-1:0]), 64'h1234);
        check("uf_sb", 64'(sb_err), 64'(1));
        repeat (3) cycle("uf_sticky");
        wb_en = 1'b1; wb_dest = 4'd15; wb_value = 32'hDEAD;
        cycle("wb15");
        idle();
        rd_addr = {4'd15, 4'd15, 4'd15};
        #1;
        check("rd15", 64'(rd_data), 64'(0));
        cycle("rd15");

        // Reset during an in-flight write-back
        idle();
        issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd4;
        repeat (2) cycle("mid_inc");
        idle();
        rst = 1'b1; wb_en = 1'b1; wb_dest = 4'd4; wb_value = 32'h55;
        cycle("mid_rst");
        rst = 1'b0;
        idle();
        issue_valid = 1'b1; rd_addr = {4'd0, 4'd0, 4'd4}; rd_used = 3'b001;
        #1;
        check("mid_rd", 64'(rd_data[DW-1:0]), 64'(0));
        check("mid_hazard", 64'(hazard), 64'(0));
        check("mid_sb", 64'(sb_err), 64'(0));
        cycle("mid_after");

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst         = ($urandom_range(0, 59) == 0);
            issue_valid = 1'($urandom_range(0, 1));
            issue_wb_en = ($urandom_range(0, 3) != 0);
            issue_dest  = pick();
            flush       = ($urandom_range(0, 7) == 0);
            rd_addr     = {pick(), pick(), pick()};
            rd_used     = 3'($urandom_range(0, 7));
            wb_en       = 1'($urandom_range(0, 1));
            wb_dest     = pick();
            wb_value    = $urandom;
            cycle("rnd");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
